sc_io_hex_display: RTL and testbench

//  Output-side display stage for the single-cycle computer. Consumes one 32-bit

---
 rtl/sc_io_hex_display_pkg.sv | 27 ++
 rtl/sc_io_hex_display_if.sv | 11 +
 rtl/sc_io_hex_display_hex7seg.sv | 21 ++
 rtl/sc_io_hex_display.sv | 123 ++++++++++++
 tb/tb_sc_io_hex_display.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/sc_io_hex_display_pkg.sv
// Shared constants for the output-port hex display: segment codes,
// FSM state encodings and a power-of-ten helper for the range check.
package sc_io_hex_display_pkg;

   // Segment patterns, bit order gfedcba, active-low
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_DIGIT [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   // FSM state encodings
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CONV = 2'd1;
   localparam logic [1:0] ST_LOAD = 2'd2;

   // 10**n at 34 bits; 10**9 still fits, so NDIG up to 9 is safe
   function automatic logic [33:0] pow10(input int unsigned n);
      logic [33:0] r;
      r = 34'd1;
      for (int unsigned i = 0; i < n; i++) begin
         r = r * 34'd10;
      end
      return r;
   endfunction

endpackage

// File: rtl/sc_io_hex_display_if.sv
// Port bundle between an output port and the hex display stage.
interface sc_io_hex_display_if #(
   parameter int unsigned NDIG = 6
);
   logic [31:0]       value;
   logic [7*NDIG-1:0] hex;
   logic              busy;

   modport master (output value, input hex, input busy);
   modport slave  (input value, output hex, output busy);
endinterface

// File: rtl/sc_io_hex_display_hex7seg.sv
// One BCD digit to active-low 7-segment pattern; dash wins over blank.
module sc_io_hex_display_hex7seg
   import sc_io_hex_display_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   input  logic       dash,
   output logic [6:0] seg
);

   // Segment select with dash/blank override
   always_comb begin
      seg = SEG_BLANK;
      if (dash) begin
         seg = SEG_DASH;
      end else if (!blank && (digit < 4'd10)) begin
         seg = SEG_DIGIT[digit];
      end
   end

endmodule

// File: rtl/sc_io_hex_display.sv
// Sequential binary-to-decimal display stage: captures a 32-bit word,
// converts it by shift-add-3 one bit per cycle, then latches all digits at once.
module sc_io_hex_display
   import sc_io_hex_display_pkg::*;
#(
   parameter int unsigned NDIG   = 6,
   parameter bit          BLANK0 = 1'b1
) (
   input logic                 clock,
   input logic                 resetn,
   sc_io_hex_display_if.slave  bus
);

   localparam int unsigned BW    = 4 * NDIG;
   localparam logic [33:0] LIMIT = pow10(NDIG);

   logic [1:0]        state;
   logic [5:0]        cnt;
   logic [31:0]       sh;
   logic [BW-1:0]     bcd;
   logic [31:0]       shown_val;
   logic              shown_ok;
   logic              ovf;
   logic [7*NDIG-1:0] hex_reg;
   logic              busy_reg;

   logic [BW-1:0]     bcd_adj;
   logic [NDIG-1:0]   blank;
   logic              zero_above;
   logic [7*NDIG-1:0] seg_dec;
   logic              start;
   logic              too_big;

   // Range check and restart condition evaluated in IDLE
   always_comb begin
      too_big = ({2'b00, bus.value} >= LIMIT);
      start   = !shown_ok || (bus.value != shown_val);
   end

   // Add-3 correction applied to every nibble before each shift
   always_comb begin
      bcd_adj = bcd;
      for (int k = 0; k < int'(NDIG); k++) begin
         if (bcd[4*k +: 4] >= 4'd5) begin
            bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
         end
      end
   end

   // Leading-zero blanking: digit k blank if it and all higher digits are zero
   always_comb begin
      blank      = '0;
      zero_above = 1'b1;
      for (int k = int'(NDIG) - 1; k >= 0; k--) begin
         zero_above = zero_above && (bcd[4*k +: 4] == 4'd0);
         blank[k]   = BLANK0 && (k != 0) && zero_above;
      end
   end

   for (genvar k = 0; k < NDIG; k++) begin : g_dig
      sc_io_hex_display_hex7seg u_seg (
         .digit (bcd[4*k +: 4]),
         .blank (blank[k]),
         .dash  (ovf),
         .seg   (seg_dec[7*k +: 7])
      );
   end

   // Control FSM, conversion datapath and latched display
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         sh        <= '0;
         bcd       <= '0;
         shown_val <= '0;
         shown_ok  <= 1'b0;
         ovf       <= 1'b0;
         hex_reg   <= {NDIG{SEG_BLANK}};
         busy_reg  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  shown_val <= bus.value;
                  shown_ok  <= 1'b1;
                  busy_reg  <= 1'b1;
                  if (too_big) begin
                     // Out of range: skip conversion, show dashes
                     ovf   <= 1'b1;
                     state <= ST_LOAD;
                  end else begin
                     ovf   <= 1'b0;
                     sh    <= bus.value;
                     bcd   <= '0;
                     cnt   <= '0;
                     state <= ST_CONV;
                  end
               end
            end
            ST_CONV: begin
               {bcd, sh} <= {bcd_adj, sh} << 1;
               cnt       <= cnt + 6'd1;
               if (cnt == 6'd31) begin
                  state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               hex_reg  <= seg_dec;
               busy_reg <= 1'b0;
               state    <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.hex  = hex_reg;
   assign bus.busy = busy_reg;

endmodule

// File: tb/tb_sc_io_hex_display.sv
// Self-checking bench for sc_io_hex_display: directed scenarios plus random
// values against a decimal reference model.
module tb_sc_io_hex_display;

   logic clock = 1'b0;
   logic resetn;

   int checks   = 0;
   int failures = 0;

   logic [6:0] seg_tab [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   always #5 clock = ~clock;

   sc_io_hex_display_if #(.NDIG(6)) bus1 ();
   sc_io_hex_display_if #(.NDIG(6)) bus2 ();

   sc_io_hex_display #(.NDIG(6), .BLANK0(1'b1)) dut1 (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus1)
   );

   sc_io_hex_display #(.NDIG(6), .BLANK0(1'b0)) dut2 (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus2)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Decimal rendering of v on 6 digits, from arithmetic on the value itself
   function automatic logic [41:0] model_hex(input logic [31:0] v, input bit blank0);
      logic [41:0]     r;
      longint unsigned p;
      longint unsigned vv;
      vv = longint'(v);
      if (vv >= 64'd1000000) return {6{7'h3F}};
      p = 1;
      for (int k = 0; k < 6; k++) begin
         if (blank0 && (k > 0) && (vv < p)) r[7*k +: 7] = 7'h7F;
         else                               r[7*k +: 7] = seg_tab[int'((vv / p) % 10)];
         p = p * 10;
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present v to DUT1 while idle and verify capture, hold and result timing
   task automatic run_conv(input string tag, input logic [31:0] v);
      logic [41:0] prev;
      int          lat;
      prev = bus1.hex;
      lat  = (longint'(v) >= 64'd1000000) ? 1 : 33;
      bus1.value = v;
      tick();
      check_val({tag, "_busy_rise"}, 64'(bus1.busy), 64'd1);
      repeat (lat - 1) tick();
      check_val({tag, "_hold"}, 64'(bus1.hex), 64'(prev));
      check_val({tag, "_busy_hold"}, 64'(bus1.busy), 64'd1);
      tick();
      check_val({tag, "_busy_fall"}, 64'(bus1.busy), 64'd0);
      check_val({tag, "_hex"}, 64'(bus1.hex), 64'(model_hex(v, 1'b1)));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [31:0] v;
      logic [31:0] last;
      bit          busy_seen;

      // Reset behaviour
      resetn     = 1'b0;
      bus1.value = 32'd0;
      bus2.value = 32'd305;
      repeat (3) tick();
      check_val("rst_hex1", 64'(bus1.hex), 64'({6{7'h7F}}));
      check_val("rst_busy1", 64'(bus1.busy), 64'd0);
      check_val("rst_hex2", 64'(bus2.hex), 64'({6{7'h7F}}));
      resetn = 1'b1;

      // Value 0 converted after reset; DUT2 converts 305 with no blanking
      run_conv("t1_zero", 32'd0);
      check_val("t6_hex", 64'(bus2.hex), 64'(model_hex(32'd305, 1'b0)));
      check_val("t6_busy", 64'(bus2.busy), 64'd0);

      // Held values must not retrigger either DUT
      busy_seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         busy_seen = busy_seen | bus1.busy | bus2.busy;
      end
      check_val("t6_no_repeat", 64'(busy_seen), 64'd0);

      run_conv("t2_123456", 32'd123456);
      run_conv("t3_ovf", 32'd1000000);
      run_conv("t3_max", 32'hFFFF_FFFF);
      run_conv("t3_999999", 32'd999999);

      // Value change mid-conversion is ignored until the next IDLE
      bus1.value = 32'd42;
      tick();
      check_val("t4_busy_rise", 64'(bus1.busy), 64'd1);
      repeat (10) tick();
      bus1.value = 32'd7;
      repeat (22) tick();
      check_val("t4_hold", 64'(bus1.hex), 64'(model_hex(32'd999999, 1'b1)));
      tick();
      check_val("t4_hex42", 64'(bus1.hex), 64'(model_hex(32'd42, 1'b1)));
      check_val("t4_busy_fall", 64'(bus1.busy), 64'd0);
      tick();
      check_val("t4_restart", 64'(bus1.busy), 64'd1);
      repeat (32) tick();
      tick();
      check_val("t4_hex7", 64'(bus1.hex), 64'(model_hex(32'd7, 1'b1)));
      check_val("t4_busy_fall7", 64'(bus1.busy), 64'd0);

      // Reset during conversion aborts it
      bus1.value = 32'd305;
      tick();
      repeat (20) tick();
      #2 resetn = 1'b0;
      #1;
      check_val("t5_rst_hex", 64'(bus1.hex), 64'({6{7'h7F}}));
      check_val("t5_rst_busy", 64'(bus1.busy), 64'd0);
      tick();
      resetn = 1'b1;
      run_conv("t5_305", 32'd305);

      // Random values biased toward small numbers and the range boundary
      last = 32'd305;
      for (int i = 0; i < 20; i++) begin
         case ($urandom_range(0, 3))
            0:       v = $urandom_range(0, 99);
            1:       v = $urandom_range(0, 999999);
            2:       v = ($urandom_range(0, 1) == 0) ? 32'd999999 : 32'd1000000;
            default: v = $urandom;
         endcase
         if (v == last) begin
            bus1.value = v;
            repeat (3) tick();
            check_val("rnd_same_idle", 64'(bus1.busy), 64'd0);
         end else begin
            run_conv($sformatf("rnd%0d_%0d", i, v), v);
         end
         last = v;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
